// File: rtl/cndm_irq_coalesce.sv
// Per-vector interrupt moderation: counts events, runs a coalescing timer and
// issues eligible vectors one at a time on a valid/ready vector-index stream.
module cndm_irq_coalesce #(
    parameter int unsigned IRQ_CNT  = 32,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned TIMER_W  = 16,
    parameter int unsigned PRESCALE = 250,
    parameter int unsigned VEC_W    = (IRQ_CNT > 1) ? $clog2(IRQ_CNT) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IRQ_CNT-1:0] irq,
    input  logic               cfg_wr_en,
    input  logic [VEC_W-1:0]   cfg_wr_vec,
    input  logic [TIMER_W-1:0] cfg_wr_time,
    input  logic [CNT_W-1:0]   cfg_wr_cnt,
    input  logic               cfg_wr_mask,
    input  logic               rearm_en,
    input  logic [VEC_W-1:0]   rearm_vec,
    output logic [VEC_W-1:0]   m_irq_vec,
    output logic               m_irq_valid,
    input  logic               m_irq_ready,
    output logic [IRQ_CNT-1:0] stat_pending,
    output logic [IRQ_CNT-1:0] stat_armed
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PS_W-1:0]    ps_cnt;
    logic               tick_c;
    logic               hs_c;
    logic [IRQ_CNT-1:0] mask_vec;
    logic [IRQ_CNT-1:0] cand_c;
    logic [VEC_W-1:0]   rr_ptr;
    logic               found_c;
    logic [VEC_W-1:0]   win_c;
    logic [VEC_W-1:0]   ptr_nxt_c;

    assign tick_c = (ps_cnt == PS_W'(PRESCALE - 1));
    assign hs_c   = m_irq_valid & m_irq_ready;

    // Shared prescaler: one timer tick every PRESCALE cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt <= '0;
        end else if (tick_c) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
        end
    end

    for (genvar v = 0; v < IRQ_CNT; v++) begin : g_vec
        logic [CNT_W-1:0]   cnt_q, cnt_d;
        logic [TIMER_W-1:0] tmr_q, tmr_d;
        logic               run_q, run_d;
        logic               armed_q, armed_d;
        logic               pend_q, pend_d;
        logic [TIMER_W-1:0] cfg_time_q;
        logic [CNT_W-1:0]   cfg_cnt_q;
        logic               mask_q;
        logic [CNT_W-1:0]   thr_c;
        logic               hs_hit_c;
        logic               cfg_hit_c;
        logic               rearm_hit_c;

        assign hs_hit_c    = hs_c && (m_irq_vec == VEC_W'(v));
        assign cfg_hit_c   = cfg_wr_en && (cfg_wr_vec == VEC_W'(v));
        assign rearm_hit_c = rearm_en && (rearm_vec == VEC_W'(v));
        assign thr_c       = (cfg_cnt_q == '0) ? CNT_W'(1) : cfg_cnt_q;

        // Next state: tick, then handshake clear, then event, then re-arm; fire on the result
        always_comb begin
            cnt_d   = cnt_q;
            tmr_d   = tmr_q;
            run_d   = run_q;
            armed_d = armed_q;
            pend_d  = pend_q;
            if (run_q && tick_c && (tmr_q != '0)) begin
                tmr_d = tmr_q - TIMER_W'(1);
            end
            if (hs_hit_c) begin
                cnt_d   = '0;
                run_d   = 1'b0;
                pend_d  = 1'b0;
                armed_d = 1'b0;
            end
            if (irq[v]) begin
                if (cnt_d != CNT_MAX) begin
                    cnt_d = cnt_d + CNT_W'(1);
                end
                if (!run_d) begin
                    tmr_d = cfg_time_q;
                    run_d = 1'b1;
                end
            end
            if (rearm_hit_c) begin
                armed_d = 1'b1;
            end
            if (armed_d && (cnt_d != '0) &&
                ((cnt_d >= thr_c) || (run_d && (tmr_d == '0)) || (cfg_time_q == '0))) begin
                pend_d = 1'b1;
            end
        end

        // Per-vector moderation state
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q   <= '0;
                tmr_q   <= '0;
                run_q   <= 1'b0;
                armed_q <= 1'b1;
                pend_q  <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                tmr_q   <= tmr_d;
                run_q   <= run_d;
                armed_q <= armed_d;
                pend_q  <= pend_d;
            end
        end

        // Per-vector configuration; a running timer keeps its current value
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cfg_time_q <= '0;
                cfg_cnt_q  <= CNT_W'(1);
                mask_q     <= 1'b0;
            end else if (cfg_hit_c) begin
                cfg_time_q <= cfg_wr_time;
                cfg_cnt_q  <= cfg_wr_cnt;
                mask_q     <= cfg_wr_mask;
            end
        end

        assign stat_pending[v] = pend_q;
        assign stat_armed[v]   = armed_q;
        assign mask_vec[v]     = mask_q;
        // The vector already held in the output register is not a candidate again
        assign cand_c[v] = pend_q && !mask_q && !(m_irq_valid && (m_irq_vec == VEC_W'(v)));
    end

    // Round-robin search starting at rr_ptr
    always_comb begin
        logic [VEC_W:0] idx;
        found_c   = 1'b0;
        win_c     = '0;
        ptr_nxt_c = rr_ptr;
        idx       = '0;
        for (int unsigned i = 0; i < IRQ_CNT; i++) begin
            idx = {1'b0, rr_ptr} + (VEC_W+1)'(i);
            if (idx >= (VEC_W+1)'(IRQ_CNT)) begin
                idx = idx - (VEC_W+1)'(IRQ_CNT);
            end
            if (!found_c && cand_c[idx[VEC_W-1:0]]) begin
                found_c = 1'b1;
                win_c   = idx[VEC_W-1:0];
            end
        end
        if (found_c) begin
            ptr_nxt_c = (win_c == VEC_W'(IRQ_CNT - 1)) ? '0 : win_c + VEC_W'(1);
        end
    end

    // Output register: reloads whenever empty or being accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_irq_valid <= 1'b0;
            m_irq_vec   <= '0;
            rr_ptr      <= '0;
        end else if (!m_irq_valid || m_irq_ready) begin
            m_irq_valid <= found_c;
            if (found_c) begin
                m_irq_vec <= win_c;
                rr_ptr    <= ptr_nxt_c;
            end
        end
    end

endmodule
